// File: rtl/freq_range_ctrl.sv
// freq_range_ctrl
//   Sequences the decade-range select of the DDFS frequency divider.
//   Up/down button rising edges move a saturating requested range (target);
//   the request is applied to freq_cntrl only on a divider wrap so the
//   divided clock never produces a runt period.
//
//   Optional feature macro: RANGE_SWEEP_EN
//     defined   - sweep_en enables an auto-sweep through 0..RANGE_MAX with
//                 a dwell of dwell_cycles clk_in cycles per range.
//     undefined - manual-only; sweep_en and dwell_cycles are ignored.
//
// Ports
//   clk_in        system clock, rising edge
//   rst_n         asynchronous active-low reset
//   btn_up        level, debounced; rising edge requests range+1
//   btn_down      level, debounced; rising edge requests range-1
//   sweep_en      level; enables auto-sweep (RANGE_SWEEP_EN only)
//   dwell_cycles  cycles spent at each range while sweeping
//   div_wrap      one-cycle pulse when the divider counter reloads
//   freq_cntrl    applied range code
//   target        requested range code
//   pending       high while a requested change waits for div_wrap
//   range_changed one-cycle pulse after freq_cntrl updates
module freq_range_ctrl #(
  parameter int unsigned RANGE_MAX = 6,
  parameter int unsigned DWELL_W   = 24
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               sweep_en,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic               div_wrap,
  output logic [2:0]         freq_cntrl,
  output logic [2:0]         target,
  output logic               pending,
  output logic               range_changed
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WRAP = 2'd1,
    DWELL     = 2'd2
  } state_t;

  localparam logic [2:0] RMAX = 3'(RANGE_MAX);

  state_t     state, state_nx;
  logic       up_q, down_q;
  logic       up_edge, down_edge;
  logic [2:0] target_nx, freq_nx;
  logic       changed_nx;
  logic       sweep_act;

`ifdef RANGE_SWEEP_EN
  logic [DWELL_W-1:0] dwell_cnt, dwell_nx, dwell_load;
  assign sweep_act  = sweep_en;
  assign dwell_load = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
`else
  logic unused_sweep;
  assign sweep_act    = 1'b0;
  assign unused_sweep = ^{sweep_en, dwell_cycles};
`endif

  assign up_edge   = btn_up & ~up_q;
  assign down_edge = btn_down & ~down_q;

  always_comb begin
    state_nx   = state;
    target_nx  = target;
    freq_nx    = freq_cntrl;
    changed_nx = 1'b0;
`ifdef RANGE_SWEEP_EN
    dwell_nx   = dwell_cnt;
`endif

    // Manual requests; simultaneous edges cancel out.
    if (!sweep_act && up_edge && !down_edge)
      target_nx = (target == RMAX) ? target : target + 3'd1;
    else if (!sweep_act && down_edge && !up_edge)
      target_nx = (target == 3'd0) ? target : target - 3'd1;

    case (state)
      IDLE: begin
`ifdef RANGE_SWEEP_EN
        if (sweep_act) begin
          dwell_nx = dwell_load;
          state_nx = DWELL;
        end else
`endif
        if (target != freq_cntrl)
          state_nx = WAIT_WRAP;
      end

      WAIT_WRAP: begin
        if (div_wrap) begin
          freq_nx    = target;
          changed_nx = 1'b1;
          state_nx   = IDLE;
`ifdef RANGE_SWEEP_EN
          // Direct hand-off to DWELL must reload the dwell counter here,
          // since IDLE (the usual loader) is skipped.
          if (sweep_act) begin
            dwell_nx = dwell_load;
            state_nx = DWELL;
          end
`endif
        end else if (target == freq_cntrl) begin
          state_nx = IDLE;
        end
      end

`ifdef RANGE_SWEEP_EN
      DWELL: begin
        if (!sweep_act) begin
          target_nx = freq_cntrl;
          state_nx  = IDLE;
        end else if (dwell_cnt <= DWELL_W'(1)) begin
          target_nx = (target == RMAX) ? 3'd0 : target + 3'd1;
          state_nx  = WAIT_WRAP;
        end else begin
          dwell_nx = dwell_cnt - DWELL_W'(1);
        end
      end
`endif

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      up_q          <= 1'b0;
      down_q        <= 1'b0;
      target        <= '0;
      freq_cntrl    <= '0;
      pending       <= 1'b0;
      range_changed <= 1'b0;
`ifdef RANGE_SWEEP_EN
      dwell_cnt     <= '0;
`endif
    end else begin
      state         <= state_nx;
      up_q          <= btn_up;
      down_q        <= btn_down;
      target        <= target_nx;
      freq_cntrl    <= freq_nx;
      pending       <= (state_nx == WAIT_WRAP);
      range_changed <= changed_nx;
`ifdef RANGE_SWEEP_EN
      dwell_cnt     <= dwell_nx;
`endif
    end
  end

endmodule

// File: tb/tb_freq_range_ctrl.sv
// tb_freq_range_ctrl
//   Self-checking bench for freq_range_ctrl. A vector table covers the
//   basic request/apply flow; hand-written sequences cover saturation,
//   asynchronous reset and (with RANGE_SWEEP_EN) the auto-sweep.
module tb_freq_range_ctrl;
  localparam int unsigned DW = 24;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn_up = 1'b0;
  logic          btn_down = 1'b0;
  logic          sweep_en = 1'b0;
  logic          div_wrap = 1'b0;
  logic [DW-1:0] dwell_cycles = '0;
  logic [2:0]    freq_cntrl;
  logic [2:0]    target;
  logic          pending;
  logic          range_changed;

  freq_range_ctrl #(.RANGE_MAX(6), .DWELL_W(DW)) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .sweep_en     (sweep_en),
    .dwell_cycles (dwell_cycles),
    .div_wrap     (div_wrap),
    .freq_cntrl   (freq_cntrl),
    .target       (target),
    .pending      (pending),
    .range_changed(range_changed)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [2:0] f;
    logic [2:0] t;
    logic       p;
    logic       r;
  } obs_t;

  typedef struct {
    string name;
    obs_t  exp;
  } sb_t;

  typedef struct packed {
    logic u;
    logic d;
    logic w;
    obs_t e;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vt[24];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic obs_t mk(int f, int t, int p, int r);
    obs_t o;
    o.f = 3'(f);
    o.t = 3'(t);
    o.p = 1'(p);
    o.r = 1'(r);
    return o;
  endfunction

  function automatic vec_t v(int u, int d, int w, int f, int t, int p, int r);
    vec_t x;
    x.u = 1'(u);
    x.d = 1'(d);
    x.w = 1'(w);
    x.e = mk(f, t, p, r);
    return x;
  endfunction

  task automatic expect_obs(input string name, input obs_t e);
    sb_t s;
    s.name = name;
    s.exp  = e;
    sb_q.push_back(s);
  endtask

  task automatic check_now();
    sb_t  s;
    obs_t got;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty: got no expected entry, required one");
      return;
    end
    s   = sb_q.pop_front();
    got = {freq_cntrl, target, pending, range_changed};
    n_cmp++;
    if (got !== s.exp) begin
      n_err++;
      $display("FAIL %s: got f=%0d t=%0d p=%0d r=%0d, required f=%0d t=%0d p=%0d r=%0d",
               s.name, got.f, got.t, got.p, got.r, s.exp.f, s.exp.t, s.exp.p, s.exp.r);
    end
  endtask

  task automatic check_cond(input string name, input bit ok, input int got, input int want);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Drive inputs #1 after a rising edge; outputs checked #1 after the next.
  task automatic step(input logic u, input logic d, input logic w,
                      input string name, input obs_t e);
    btn_up   = u;
    btn_down = d;
    div_wrap = w;
    expect_obs(name, e);
    @(posedge clk_in);
    #1;
    check_now();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    int prev;
    int e;
    int last;
    int cyc;

    //              u d w  f t p r
    vt[0]  = v(0, 0, 1, 0, 0, 0, 0);  // wrap while idle ignored
    vt[1]  = v(1, 0, 0, 0, 1, 0, 0);  // up edge -> target 1
    vt[2]  = v(1, 0, 0, 0, 1, 1, 0);  // held, no new edge; pending rises
    vt[3]  = v(0, 0, 0, 0, 1, 1, 0);
    vt[4]  = v(0, 0, 0, 0, 1, 1, 0);
    vt[5]  = v(0, 0, 0, 0, 1, 1, 0);
    vt[6]  = v(0, 0, 1, 1, 1, 0, 1);  // wrap 5 cycles after edge -> apply
    vt[7]  = v(0, 0, 0, 1, 1, 0, 0);  // pulse lasts one cycle
    vt[8]  = v(1, 1, 0, 1, 1, 0, 0);  // simultaneous edges cancel
    vt[9]  = v(0, 0, 0, 1, 1, 0, 0);
    vt[10] = v(1, 0, 0, 1, 2, 0, 0);  // up
    vt[11] = v(0, 0, 0, 1, 2, 1, 0);
    vt[12] = v(0, 1, 0, 1, 1, 1, 0);  // down reverses the request
    vt[13] = v(0, 0, 0, 1, 1, 0, 0);  // pending drops, no pulse
    vt[14] = v(0, 0, 1, 1, 1, 0, 0);
    vt[15] = v(1, 0, 0, 1, 2, 0, 0);
    vt[16] = v(0, 0, 1, 1, 2, 1, 0);  // wrap in IDLE ignored
    vt[17] = v(0, 0, 1, 2, 2, 0, 1);
    vt[18] = v(0, 1, 1, 2, 1, 0, 0);
    vt[19] = v(0, 0, 1, 2, 1, 1, 0);
    vt[20] = v(0, 0, 0, 2, 1, 1, 0);
    vt[21] = v(0, 1, 1, 1, 0, 0, 1);  // applies target sampled on wrap cycle
    vt[22] = v(0, 0, 0, 1, 0, 1, 0);
    vt[23] = v(0, 0, 1, 0, 0, 0, 1);

    // Reset state while held in reset
    #2;
    expect_obs("reset_state", mk(0, 0, 0, 0));
    check_now();
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;

    // Idle after reset, with periodic wraps
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b0, 1'((i % 4) == 0), "idle_after_reset", mk(0, 0, 0, 0));

    // Table-driven basic flow
    for (int i = 0; i < 24; i++)
      step(vt[i].u, vt[i].d, vt[i].w, $sformatf("vec%0d", i), vt[i].e);

    // Saturation upward at RANGE_MAX
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      e = (prev == 6) ? 6 : prev + 1;
      step(1'b1, 1'b0, 1'b0, "sat_up_press", mk(prev, e, 0, 0));
      step(1'b0, 1'b0, 1'b0, "sat_up_wait",  mk(prev, e, int'(e != prev), 0));
      step(1'b0, 1'b0, 1'b1, "sat_up_wrap",  mk(e, e, 0, int'(e != prev)));
      step(1'b0, 1'b0, 1'b0, "sat_up_hold",  mk(e, e, 0, 0));
      prev = e;
    end
    // Saturation downward at 0
    for (int i = 0; i < 8; i++) begin
      e = (prev == 0) ? 0 : prev - 1;
      step(1'b0, 1'b1, 1'b0, "sat_dn_press", mk(prev, e, 0, 0));
      step(1'b0, 1'b0, 1'b0, "sat_dn_wait",  mk(prev, e, int'(e != prev), 0));
      step(1'b0, 1'b0, 1'b1, "sat_dn_wrap",  mk(e, e, 0, int'(e != prev)));
      step(1'b0, 1'b0, 1'b0, "sat_dn_hold",  mk(e, e, 0, 0));
      prev = e;
    end

    // Asynchronous reset with a request pending (target=2, freq_cntrl=1)
    step(1'b1, 1'b0, 1'b0, "rst_setup0", mk(0, 1, 0, 0));
    step(1'b0, 1'b0, 1'b0, "rst_setup1", mk(0, 1, 1, 0));
    step(1'b0, 1'b0, 1'b1, "rst_setup2", mk(1, 1, 0, 1));
    step(1'b0, 1'b0, 1'b0, "rst_setup3", mk(1, 1, 0, 0));
    step(1'b1, 1'b0, 1'b0, "rst_setup4", mk(1, 2, 0, 0));
    step(1'b0, 1'b0, 1'b0, "rst_setup5", mk(1, 2, 1, 0));
    #2;
    rst_n = 1'b0;
    #1;
    expect_obs("async_reset", mk(0, 0, 0, 0));
    check_now();
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b1, "after_reset_wrap", mk(0, 0, 0, 0));

    // Auto-sweep
    dwell_cycles = DW'(3);
    sweep_en     = 1'b1;
    div_wrap     = 1'b1;
`ifdef RANGE_SWEEP_EN
    last = 0;
    for (int k = 0; k < 8; k++) begin
      e   = (k + 1) % 7;
      cyc = 0;
      do begin
        @(posedge clk_in);
        #1;
        cyc++;
      end while (freq_cntrl == 3'(last) && cyc < 20);
      check_cond($sformatf("sweep_step%0d_timeout", k), cyc < 20, cyc, 20);
      expect_obs($sformatf("sweep_step%0d", k), mk(e, e, 0, 1));
      check_now();
      if (k > 0)
        check_cond($sformatf("sweep_dwell%0d", k), cyc >= 3, cyc, 3);
      last = e;
    end
    sweep_en = 1'b0;
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, 1'b1, "sweep_stopped", mk(1, 1, 0, 0));
`else
    for (int i = 0; i < 30; i++)
      step(1'b0, 1'b0, 1'b1, "sweep_disabled", mk(0, 0, 0, 0));
    sweep_en = 1'b0;
`endif
    div_wrap = 1'b0;

    check_cond("scoreboard_drained", sb_q.size() == 0, sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
